// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit that owns the HI/LO registers.
//
// Ports:
//   clk    in   1   clock, all state changes on the rising edge
//   reset  in   1   synchronous active-high reset (aborts any in-flight op)
//   start  in   1   EX-stage md request valid
//   op     in   3   0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MADDU
//   A, B   in   32  operands (rs, rt)
//   busy   out  1   operation in flight (registered)
//   done   out  1   one-cycle pulse after HI/LO were written by a completing op
//   hi_o   out  32  HI register
//   lo_o   out  32  LO register
//
// Parameters: MULT_CYCLES / DIV_CYCLES (1..15) set the busy period length.
// Configuration: define MD_UNIT_MADD_EN to enable MADD/MADDU (accumulate into
// {HI,LO}); without it op 6/7 are accepted as no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // ---------------------------------------------------------------------------
  // Datapath: everything is computed from the latched operands, so the
  // forwarded A/B may change freely once the op has been accepted.
  // ---------------------------------------------------------------------------
  logic signed [63:0] a_sx, b_sx;
  logic        [63:0] prod_s, prod_u, acc;
  logic        [31:0] b_div;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = 64'(a_sx * b_sx);
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    acc    = {hi_q, lo_q};
    // The divider never sees zero; a zero divisor leaves HI/LO untouched anyway.
    b_div  = (b_q == 32'b0) ? 32'd1 : b_q;
    // SV signed division truncates toward zero and the remainder keeps the
    // sign of the dividend, which is exactly the MIPS DIV definition.
    quo_s  = $signed(a_q) / $signed(b_div);
    rem_s  = $signed(a_q) % $signed(b_div);
    quo_u  = a_q / b_div;
    rem_u  = a_q % b_div;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op_e'(op))
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = MULT_N;
              op_d    = md_op_e'(op);
              a_d     = A;
              b_d     = B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = DIV_N;
              op_d    = md_op_e'(op);
              a_d     = A;
              b_d     = B;
            end
            OP_MADD, OP_MADDU: begin
`ifdef MD_UNIT_MADD_EN
              state_d = RUN;
              cnt_d   = MULT_N;
              op_d    = md_op_e'(op);
              a_d     = A;
              b_d     = B;
`else
              state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
          endcase
        end
      end

      RUN: begin
        // start is ignored here: the hazard unit is responsible for stalling.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q != 32'b0) begin
                lo_d = quo_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'b0) begin
                lo_d = quo_u;
                hi_d = rem_u;
              end
            end
`ifdef MD_UNIT_MADD_EN
            // Accumulates onto HI/LO as they stand at completion.
            OP_MADD:  {hi_d, lo_d} = acc + prod_s;
            OP_MADDU: {hi_d, lo_d} = acc + prod_u;
`endif
            default: begin
              hi_d = hi_q;
              lo_d = lo_q;
            end
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A reset on the completion edge wins over the result write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_MULT;
      a_q     <= 32'b0;
      b_q     <= 32'b0;
      hi_q    <= 32'b0;
      lo_q    <= 32'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // acc is only consumed when MADD is built in.
  logic unused_acc;
  assign unused_acc = ^acc;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases followed by random ops, all checked
// against an arithmetic reference model of HI/LO and the busy/done timing.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi_o, lo_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mh, ml;  // model HI/LO

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Reference model: new HI/LO from the architectural definition of each op,
  // and the number of busy cycles it should take (0 = single-cycle / no-op).
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int n);
    longint      sa, sb, q, r, ma, mb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = 0;
    case (o)
      3'd0: begin p = 64'(sa * sb); {hi, lo} = p; n = MULT_CYCLES; end
      3'd1: begin p = 64'(a) * 64'(b); {hi, lo} = p; n = MULT_CYCLES; end
      3'd2: begin
        n = DIV_CYCLES;
        if (b != 0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ma / mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          r  = sa - q * sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      3'd3: begin
        n = DIV_CYCLES;
        if (b != 0) begin lo = a / b; hi = a % b; end
      end
      3'd4: hi = a;
      3'd5: lo = a;
`ifdef MD_UNIT_MADD_EN
      3'd6: begin p = {hi, lo} + 64'(sa * sb); {hi, lo} = p; n = MULT_CYCLES; end
      3'd7: begin p = {hi, lo} + 64'(a) * 64'(b); {hi, lo} = p; n = MULT_CYCLES; end
`endif
      default: n = 0;
    endcase
  endtask

  // Called at a negedge with the unit idle. inj drives an MTHI request while busy.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit inj);
    logic [31:0] nh, nl;
    int n;
    nh = mh; nl = ml;
    model(o, a, b, nh, nl, n);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom);
    if (n == 0) begin
      chk1("busy_single", busy, 1'b0);
      chk1("done_single", done, 1'b0);
      chk("hi_single", hi_o, nh);
      chk("lo_single", lo_o, nl);
    end else begin
      for (int k = 1; k <= n; k++) begin
        chk1("busy_run", busy, 1'b1);
        chk1("done_run", done, 1'b0);
        chk("hi_run", hi_o, mh);
        chk("lo_run", lo_o, ml);
        if (inj && k == 2) begin
          start = 1'b1; op = 3'd4; A = $urandom;
        end else begin
          start = 1'b0; A = $urandom; B = $urandom;
        end
        @(negedge clk);
      end
      start = 1'b0;
      chk1("busy_end", busy, 1'b0);
      chk1("done_pulse", done, 1'b1);
      chk("hi_result", hi_o, nh);
      chk("lo_result", lo_o, nl);
      @(negedge clk);
      chk1("done_clear", done, 1'b0);
    end
    mh = nh; ml = nl;
  endtask

  // Accept an op, then assert reset during busy cycle k (k==n hits the completion edge).
  task automatic do_abort(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int k);
    logic [31:0] nh, nl;
    int n;
    nh = mh; nl = ml;
    model(o, a, b, nh, nl, n);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk("abort_hi", hi_o, 32'h0);
    chk("abort_lo", lo_o, 32'h0);
    mh = 32'h0; ml = 32'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
      chk1("abort_no_busy", busy, 1'b0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'h0; B = 32'h0;
    mh = 32'h0; ml = 32'h0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);

    // Directed cases
    do_op(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);      // MULT -3*7
    chk("mult_hi_const", hi_o, 32'hFFFFFFFF);
    chk("mult_lo_const", lo_o, 32'hFFFFFFEB);
    do_op(3'd3, 32'd100, 32'd7, 1'b0);           // DIVU
    chk("divu_lo_const", lo_o, 32'd14);
    chk("divu_hi_const", hi_o, 32'd2);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);      // DIV -7/2
    chk("div_lo_const", lo_o, 32'hFFFFFFFD);
    chk("div_hi_const", hi_o, 32'hFFFFFFFF);
    do_op(3'd4, 32'd1, 32'd0, 1'b0);             // MTHI 1
    do_op(3'd5, 32'd2, 32'd0, 1'b0);             // MTLO 2
    do_op(3'd2, 32'd5, 32'd0, 1'b0);             // DIV by zero
    chk("div0_hi_const", hi_o, 32'd1);
    chk("div0_lo_const", lo_o, 32'd2);
    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1);      // MULTU with ignored MTHI mid-run
    chk("multu_hi_const", hi_o, 32'd1);
    chk("multu_lo_const", lo_o, 32'hFFFFFFFE);
    do_op(3'd5, 32'h12345678, 32'd0, 1'b0);      // MTLO
    chk("mtlo_const", lo_o, 32'h12345678);
    do_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    do_abort(3'd2, 32'd50, 32'd3, 3);            // reset at cycle 3 of a DIV
    do_op(3'd4, 32'h0000ABCD, 32'd0, 1'b0);
    do_abort(3'd0, 32'd9, 32'd9, MULT_CYCLES);   // reset on completion edge

    // MADD / no-op check
    do_op(3'd4, 32'h0, 32'd0, 1'b0);
    do_op(3'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
    do_op(3'd7, 32'd1, 32'd1, 1'b0);
`ifdef MD_UNIT_MADD_EN
    chk("maddu_hi_const", hi_o, 32'd1);
    chk("maddu_lo_const", lo_o, 32'd0);
`else
    chk("maddu_off_hi", hi_o, 32'd0);
    chk("maddu_off_lo", lo_o, 32'hFFFFFFFF);
`endif
    do_op(3'd6, 32'hFFFFFFFF, 32'd3, 1'b0);      // signed MADD (or no-op)

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'h0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if (ro == 3'd2 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      do_op(ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
